// File: rtl/dmem_responder.sv
// Memory-side responder for the data cache refill/write port.
// Services one read, byte-masked write or aligned line read at a time after a fixed latency.
module dmem_responder #(
   parameter int ADDR_W    = 12,
   parameter int DATA_W    = 32,
   parameter int LAT       = 4,
   parameter int BURST_LEN = 4
) (
   input  logic                CLK,
   input  logic                RSTn,
   input  logic                REQ_VALID,
   output logic                REQ_READY,
   input  logic                REQ_WE,
   input  logic                REQ_BURST,
   input  logic [ADDR_W-1:0]   REQ_ADDR,
   input  logic [DATA_W/8-1:0] REQ_BE,
   input  logic [DATA_W-1:0]   REQ_WDATA,
   output logic                RSP_VALID,
   input  logic                RSP_READY,
   output logic [DATA_W-1:0]   RSP_DATA,
   output logic                RSP_LAST,
   output logic                RSP_WACK
);

   localparam int BE_W   = DATA_W / 8;
   localparam int BEAT_W = $clog2(BURST_LEN);
   localparam int LAT_W  = (LAT > 1) ? $clog2(LAT) : 1;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [LAT_W-1:0]    lat_cnt;
   logic [BEAT_W-1:0]   beat_cnt;
   logic [BEAT_W-1:0]   beat_next;
   logic                we_q;
   logic                burst_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [BE_W-1:0]     be_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   rsp_data;
   logic [DATA_W-1:0]   mem [DEPTH];

   logic                accept;
   logic                enter_resp;
   logic                beat_adv;
   logic                finish;
   logic                is_last;
   logic                cmd_we;
   logic                cmd_burst;
   logic [ADDR_W-1:0]   cmd_addr;
   logic [BE_W-1:0]     cmd_be;
   logic [DATA_W-1:0]   cmd_wdata;
   logic [ADDR_W-1:0]   rd_addr;

   // With LAT==1 the commit happens on the accept edge itself, so the command
   // is taken straight from the request pins while idle.
   always_comb begin
      cmd_we    = we_q;
      cmd_burst = burst_q;
      cmd_addr  = addr_q;
      cmd_be    = be_q;
      cmd_wdata = wdata_q;
      if (state == IDLE) begin
         cmd_we    = REQ_WE;
         cmd_burst = REQ_BURST & ~REQ_WE;
         cmd_addr  = REQ_ADDR;
         cmd_be    = REQ_BE;
         cmd_wdata = REQ_WDATA;
      end
   end

   assign REQ_READY = RSTn && (state == IDLE);
   assign accept    = (state == IDLE) && REQ_VALID;
   assign beat_next = beat_cnt + BEAT_W'(1);
   assign is_last   = (state == RESP) && (!burst_q || beat_cnt == BEAT_W'(BURST_LEN - 1));

   always_comb begin
      state_next = state;
      enter_resp = 1'b0;
      beat_adv   = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (REQ_VALID) begin
               if (LAT == 1) begin
                  state_next = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_next = WAIT;
               end
            end
         end
         WAIT: begin
            if (lat_cnt == '0) begin
               state_next = RESP;
               enter_resp = 1'b1;
            end
         end
         RESP: begin
            if (RSP_READY) begin
               if (is_last) begin
                  state_next = IDLE;
                  finish     = 1'b1;
               end else begin
                  beat_adv = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Bursts stay inside their aligned block: only the low beat bits ever change.
   always_comb begin
      rd_addr = {addr_q[ADDR_W-1:BEAT_W], beat_next};
      if (enter_resp) begin
         rd_addr = cmd_burst ? {cmd_addr[ADDR_W-1:BEAT_W], {BEAT_W{1'b0}}} : cmd_addr;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state    <= IDLE;
         lat_cnt  <= '0;
         beat_cnt <= '0;
         rsp_data <= '0;
         we_q     <= 1'b0;
         burst_q  <= 1'b0;
         addr_q   <= '0;
         be_q     <= '0;
         wdata_q  <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            we_q    <= REQ_WE;
            burst_q <= REQ_BURST & ~REQ_WE;
            addr_q  <= REQ_ADDR;
            be_q    <= REQ_BE;
            wdata_q <= REQ_WDATA;
            lat_cnt <= LAT_W'(LAT - 1);
         end else if (state == WAIT && lat_cnt != '0) begin
            lat_cnt <= lat_cnt - LAT_W'(1);
         end
         if (enter_resp) begin
            beat_cnt <= '0;
            rsp_data <= cmd_we ? '0 : mem[rd_addr];
         end else if (beat_adv) begin
            beat_cnt <= beat_next;
            rsp_data <= mem[rd_addr];
         end else if (finish) begin
            beat_cnt <= '0;
            rsp_data <= '0;
         end
      end
   end

   // Array is never cleared; a reset before the commit edge drops the write.
   always_ff @(posedge CLK) begin
      if (RSTn && enter_resp && cmd_we) begin
         for (int i = 0; i < BE_W; i++) begin
            if (cmd_be[i]) begin
               mem[cmd_addr][8*i +: 8] <= cmd_wdata[8*i +: 8];
            end
         end
      end
   end

   assign RSP_VALID = (state == RESP);
   assign RSP_WACK  = (state == RESP) && we_q;
   assign RSP_LAST  = is_last;
   assign RSP_DATA  = rsp_data;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised and directed checks of dmem_responder against a word-array reference model.
module tb_dmem_responder;

   localparam int LAT = 4;

   logic        clk;
   logic        rstn;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic        req_burst;
   logic [11:0] req_addr;
   logic [3:0]  req_be;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_last;
   logic        rsp_wack;

   int checks = 0;
   int errors = 0;
   logic [31:0] ref_mem [4096];

   dmem_responder #(.ADDR_W(12), .DATA_W(32), .LAT(LAT), .BURST_LEN(4)) dut (
      .CLK(clk), .RSTn(rstn),
      .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WE(req_we), .REQ_BURST(req_burst),
      .REQ_ADDR(req_addr), .REQ_BE(req_be), .REQ_WDATA(req_wdata),
      .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_DATA(rsp_data),
      .RSP_LAST(rsp_last), .RSP_WACK(rsp_wack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic void model_write(input logic [11:0] a, input logic [3:0] be, input logic [31:0] wd);
      for (int i = 0; i < 4; i++)
         if (be[i]) ref_mem[a][8*i +: 8] = wd[8*i +: 8];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic we, input logic burst, input logic [11:0] a, input logic [3:0] be,
                        input logic [31:0] wd, output int ok);
      ok = 0;
      req_valid = 1'b1; req_we = we; req_burst = burst; req_addr = a; req_be = be; req_wdata = wd;
      for (int n = 0; n < 20; n++) begin
         if (req_ready) begin
            step();
            ok = 1;
            break;
         end
         step();
      end
      req_valid = 1'b0; req_we = 1'b0; req_burst = 1'b0; req_addr = '0; req_be = '0; req_wdata = '0;
   endtask

   task automatic recv(input int max_stall, output logic [31:0] d, output logic l, output logic w,
                       output int wait_cyc, output bit stable);
      int k;
      wait_cyc = 0;
      stable = 1'b1;
      while (!rsp_valid && wait_cyc < 100) begin
         step();
         wait_cyc++;
      end
      if (!rsp_valid) begin
         wait_cyc = -1; d = '0; l = 1'b0; w = 1'b0;
         return;
      end
      d = rsp_data; l = rsp_last; w = rsp_wack;
      if (max_stall > 0) begin
         k = $urandom_range(max_stall, 0);
         rsp_ready = 1'b0;
         repeat (k) begin
            step();
            if (rsp_valid !== 1'b1 || rsp_data !== d || rsp_last !== l) stable = 1'b0;
         end
         rsp_ready = 1'b1;
      end
      step();
   endtask

   task automatic write_word(input logic [11:0] a, input logic [3:0] be, input logic [31:0] wd);
      int ok, cyc;
      logic [31:0] d;
      logic l, w;
      bit st;
      issue(1'b1, 1'b0, a, be, wd, ok);
      recv(0, d, l, w, cyc, st);
      model_write(a, be, wd);
   endtask

   task automatic test_reset();
      rstn = 1'b0; rsp_ready = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_burst = 1'b0; req_addr = '0; req_be = '0; req_wdata = '0;
      repeat (3) step();
      checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_ready: got %b want 0", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
      checks++; if (rsp_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_last: got %b want 0", rsp_last); end
      checks++; if (rsp_wack !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_wack: got %b want 0", rsp_wack); end
      checks++; if (rsp_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_rsp_data: got %h want 0", rsp_data); end
      rstn = 1'b1;
      step();
      checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ready: got %b want 1", req_ready); end
   endtask

   task automatic test_write_ack();
      int ok, cyc;
      logic [31:0] d;
      logic l, w;
      bit st;
      issue(1'b1, 1'b0, 12'h010, 4'hF, 32'hDEADBEEF, ok);
      checks++; if (ok != 1) begin errors++; $display("[TB] FAIL t1_accept: got %0d want 1", ok); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL t1_busy_ready: got %b want 0", req_ready); end
      recv(0, d, l, w, cyc, st);
      model_write(12'h010, 4'hF, 32'hDEADBEEF);
      checks++; if (cyc != LAT) begin errors++; $display("[TB] FAIL t1_latency: got %0d want %0d", cyc, LAT); end
      checks++; if (w !== 1'b1 || l !== 1'b1 || d !== 32'h0) begin
         errors++; $display("[TB] FAIL t1_ack: got wack=%b last=%b data=%h want 1 1 0", w, l, d); end
      checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL t1_back_idle: got ready=%b valid=%b want 1 0", req_ready, rsp_valid); end
   endtask

   task automatic test_single_read();
      int ok, cyc;
      logic [31:0] d;
      logic l, w;
      bit st;
      issue(1'b0, 1'b0, 12'h010, 4'h0, 32'h0, ok);
      recv(0, d, l, w, cyc, st);
      checks++; if (cyc != LAT) begin errors++; $display("[TB] FAIL t2_latency: got %0d want %0d", cyc, LAT); end
      checks++; if (d !== ref_mem[12'h010]) begin errors++; $display("[TB] FAIL t2_data: got %h want %h", d, ref_mem[12'h010]); end
      checks++; if (l !== 1'b1 || w !== 1'b0) begin errors++; $display("[TB] FAIL t2_flags: got last=%b wack=%b want 1 0", l, w); end
   endtask

   task automatic test_byte_enable();
      int ok, cyc;
      logic [31:0] d;
      logic l, w;
      bit st;
      issue(1'b1, 1'b0, 12'h010, 4'b0010, 32'h0000AA00, ok);
      recv(0, d, l, w, cyc, st);
      model_write(12'h010, 4'b0010, 32'h0000AA00);
      checks++; if (w !== 1'b1) begin errors++; $display("[TB] FAIL t3_wack: got %b want 1", w); end
      issue(1'b0, 1'b0, 12'h010, 4'h0, 32'h0, ok);
      recv(0, d, l, w, cyc, st);
      checks++; if (d !== 32'hDEADAAEF) begin errors++; $display("[TB] FAIL t3_merge: got %h want DEADAAEF", d); end
   endtask

   task automatic test_burst_backpressure();
      int ok, cyc;
      logic [31:0] d;
      logic l, w;
      bit st;
      for (int i = 0; i < 4; i++) write_word(12'h010 + 12'(i), 4'hF, 32'(i + 1));
      issue(1'b0, 1'b1, 12'h013, 4'h0, 32'h0, ok);
      recv(0, d, l, w, cyc, st);
      checks++; if (cyc != LAT || d !== 32'd1 || l !== 1'b0) begin
         errors++; $display("[TB] FAIL t4_beat1: got lat=%0d data=%h last=%b want %0d 1 0", cyc, d, l, LAT); end
      recv(0, d, l, w, cyc, st);
      checks++; if (d !== 32'd2 || l !== 1'b0) begin errors++; $display("[TB] FAIL t4_beat2: got %h last=%b want 2 0", d, l); end
      rsp_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd3 || rsp_last !== 1'b0) begin
            errors++; $display("[TB] FAIL t4_hold: got valid=%b data=%h last=%b want 1 3 0", rsp_valid, rsp_data, rsp_last); end
      end
      rsp_ready = 1'b1;
      recv(0, d, l, w, cyc, st);
      checks++; if (d !== 32'd3 || l !== 1'b0) begin errors++; $display("[TB] FAIL t4_beat3: got %h last=%b want 3 0", d, l); end
      recv(0, d, l, w, cyc, st);
      checks++; if (d !== 32'd4 || l !== 1'b1) begin errors++; $display("[TB] FAIL t4_beat4: got %h last=%b want 4 1", d, l); end
   endtask

   task automatic test_burst_top();
      int ok, cyc;
      logic [31:0] d;
      logic l, w;
      bit st;
      write_word(12'h000, 4'hF, 32'hA5A5A5A5);
      for (int i = 0; i < 4; i++) write_word(12'hFFC + 12'(i), 4'hF, $urandom);
      issue(1'b0, 1'b1, 12'hFFE, 4'h0, 32'h0, ok);
      for (int i = 0; i < 4; i++) begin
         recv(0, d, l, w, cyc, st);
         checks++; if (d !== ref_mem[12'hFFC + 12'(i)] || l !== (i == 3)) begin
            errors++; $display("[TB] FAIL t5_beat%0d: got %h last=%b want %h %b", i, d, l, ref_mem[12'hFFC + 12'(i)], i == 3); end
      end
   endtask

   task automatic test_reset_abort();
      int ok, cyc;
      logic [31:0] d;
      logic l, w;
      bit st;
      write_word(12'h020, 4'hF, 32'hCAFEF00D);
      issue(1'b1, 1'b0, 12'h020, 4'hF, 32'h12345678, ok);
      step();
      rstn = 1'b0;
      step();
      checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL t6_abort: got valid=%b ready=%b want 0 0", rsp_valid, req_ready); end
      rstn = 1'b1;
      cyc = 0;
      for (int i = 0; i < LAT + 2; i++) begin
         step();
         if (rsp_valid !== 1'b0) cyc++;
      end
      checks++; if (cyc != 0 || req_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL t6_no_response: got stray=%0d ready=%b want 0 1", cyc, req_ready); end
      issue(1'b0, 1'b0, 12'h020, 4'h0, 32'h0, ok);
      recv(0, d, l, w, cyc, st);
      checks++; if (d !== ref_mem[12'h020]) begin errors++; $display("[TB] FAIL t6_old_value: got %h want %h", d, ref_mem[12'h020]); end
   endtask

   task automatic test_random();
      int ok, cyc, op;
      logic [31:0] d, wd;
      logic l, w;
      logic [11:0] a, base;
      logic [3:0] be;
      bit st;
      for (int i = 0; i < 64; i++) write_word(12'h100 + 12'(i), 4'hF, $urandom);
      for (int n = 0; n < 60; n++) begin
         op = $urandom_range(2, 0);
         a  = 12'h100 + 12'($urandom_range(63, 0));
         if (op == 0) begin
            be = 4'($urandom); wd = $urandom;
            issue(1'b1, 1'($urandom), a, be, wd, ok);
            recv(2, d, l, w, cyc, st);
            model_write(a, be, wd);
            checks++; if (cyc != LAT || w !== 1'b1 || l !== 1'b1 || d !== 32'h0 || !st) begin
               errors++; $display("[TB] FAIL rnd_write %0d: got lat=%0d wack=%b last=%b data=%h stable=%b want %0d 1 1 0 1",
                                  n, cyc, w, l, d, st, LAT); end
         end else if (op == 1) begin
            issue(1'b0, 1'b0, a, 4'($urandom), $urandom, ok);
            recv(2, d, l, w, cyc, st);
            checks++; if (cyc != LAT || d !== ref_mem[a] || l !== 1'b1 || w !== 1'b0 || !st) begin
               errors++; $display("[TB] FAIL rnd_read %0d @%h: got lat=%0d data=%h last=%b wack=%b stable=%b want %0d %h 1 0 1",
                                  n, a, cyc, d, l, w, st, LAT, ref_mem[a]); end
         end else begin
            base = a & ~12'd3;
            issue(1'b0, 1'b1, a, 4'h0, 32'h0, ok);
            for (int i = 0; i < 4; i++) begin
               recv(2, d, l, w, cyc, st);
               checks++; if (cyc != ((i == 0) ? LAT : 0) || d !== ref_mem[base + 12'(i)] || l !== (i == 3) || w !== 1'b0 || !st) begin
                  errors++; $display("[TB] FAIL rnd_burst %0d beat %0d: got lat=%0d data=%h last=%b wack=%b stable=%b want data=%h last=%b",
                                     n, i, cyc, d, l, w, st, ref_mem[base + 12'(i)], i == 3); end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_ack();
      test_single_read();
      test_byte_enable();
      test_burst_backpressure();
      test_burst_top();
      test_reset_abort();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
